// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Holds the fetch PC and the IF/ID pipeline register. The instruction memory
// is read combinationally from inst_addr (== PC), so the fetched word lands in
// IF_ID one cycle after its PC is presented.
//
// Ports
//   clk            in   1   single clock, all state on rising edge
//   reset_b        in   1   synchronous, active-low reset
//   inst_addr      out  32  instruction memory address (== PC)
//   inst_data      in   32  instruction word for inst_addr
//   uart_wait      in   1   global freeze: PC and IF_ID hold unconditionally
//   bubble         in   1   load-use stall from decode
//   PCSrcJ         in   1   decode j/jal redirect
//   PCSrcJR        in   1   decode jr/jalr redirect
//   jump_address   in   32  j/jal target
//   jr_address     in   32  jr/jalr target
//   branch_taken   in   1   execute-stage resolved taken branch
//   branch_address in   32  branch target
//   interrupt      in   1   decode interrupt accept
//   exception      in   1   decode illegal-instruction trap
//   PC             out  32  current fetch PC
//   IF_ID          out  65  {valid, PC_Plus4[31:0], Instruction[31:0]}
//
// Next-PC priority (highest first):
//   interrupt > exception > branch_taken > jr (no bubble) > j (no bubble)
//   > bubble (hold) > sequential PC+4
// Every redirect flushes IF_ID to zero on the same edge. A jump that arrives
// with a bubble is not dropped: decode keeps PCSrcJ/PCSrcJR asserted and the
// jump is taken on the first cycle the bubble clears.
// ----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset_b,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  input  logic        uart_wait,
  input  logic        bubble,
  input  logic        PCSrcJ,
  input  logic        PCSrcJR,
  input  logic [31:0] jump_address,
  input  logic [31:0] jr_address,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  input  logic        interrupt,
  input  logic        exception,
  output logic [31:0] PC,
  output logic [64:0] IF_ID
);

  // Which source decides the next PC this cycle.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_IRQ,
    SEL_EXC,
    SEL_BRANCH,
    SEL_JR,
    SEL_J
  } pc_sel_t;

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [64:0] if_id_reg;
  logic [64:0] if_id_next;
  logic [31:0] pc_plus4;
  pc_sel_t     pc_sel;
  logic        flush;

  // Redirect targets are word aligned; the two low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] target);
    return target & 32'hFFFF_FFFC;
  endfunction

  // The increment never carries into bit 31: the kernel/user half of the
  // address space only changes through an explicit redirect target.
  assign pc_plus4 = {pc_reg[31], pc_reg[30:0] + 31'd4};

  // Next-PC source selection.
  always_comb begin
    pc_sel = SEL_SEQ;
    if (uart_wait) begin
      pc_sel = SEL_HOLD;
    end else if (interrupt) begin
      pc_sel = SEL_IRQ;           // wins over a simultaneous exception
    end else if (exception) begin
      pc_sel = SEL_EXC;
    end else if (branch_taken) begin
      pc_sel = SEL_BRANCH;        // older execute-stage op beats the stall
    end else if (bubble) begin
      pc_sel = SEL_HOLD;          // also defers any pending j/jr
    end else if (PCSrcJR) begin
      pc_sel = SEL_JR;
    end else if (PCSrcJ) begin
      pc_sel = SEL_J;
    end
  end

  // Next-state values for PC and IF_ID.
  always_comb begin
    pc_next    = pc_reg;
    if_id_next = if_id_reg;
    flush      = 1'b0;
    unique case (pc_sel)
      SEL_HOLD: begin
        pc_next    = pc_reg;
        if_id_next = if_id_reg;
      end
      SEL_SEQ: begin
        pc_next    = pc_plus4;
        if_id_next = {1'b1, pc_plus4, inst_data};
      end
      SEL_IRQ: begin
        pc_next = word_align(IRQ_VEC);
        flush   = 1'b1;
      end
      SEL_EXC: begin
        pc_next = word_align(EXC_VEC);
        flush   = 1'b1;
      end
      SEL_BRANCH: begin
        pc_next = word_align(branch_address);
        flush   = 1'b1;
      end
      SEL_JR: begin
        pc_next = word_align(jr_address);
        flush   = 1'b1;
      end
      SEL_J: begin
        pc_next = word_align(jump_address);
        flush   = 1'b1;
      end
      default: begin
        pc_next    = pc_reg;
        if_id_next = if_id_reg;
      end
    endcase
    // A redirect squashes the instruction fetched down the wrong path.
    if (flush) begin
      if_id_next = 65'd0;
    end
  end

  // State registers; reset overrides the freeze and every redirect.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      pc_reg    <= RESET_PC;
      if_id_reg <= 65'd0;
    end else begin
      pc_reg    <= pc_next;
      if_id_reg <= if_id_next;
    end
  end

  assign PC        = pc_reg;
  assign inst_addr = pc_reg;
  assign IF_ID     = if_id_reg;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        uart_wait;
  logic        bubble;
  logic        PCSrcJ;
  logic        PCSrcJR;
  logic [31:0] jump_address;
  logic [31:0] jr_address;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        interrupt;
  logic        exception;
  logic [31:0] PC;
  logic [64:0] IF_ID;

  int check_cnt = 0;
  int pass_cnt  = 0;
  bit check_en  = 1'b0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset_b(reset_b), .inst_addr(inst_addr), .inst_data(inst_data),
    .uart_wait(uart_wait), .bubble(bubble), .PCSrcJ(PCSrcJ), .PCSrcJR(PCSrcJR),
    .jump_address(jump_address), .jr_address(jr_address),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .interrupt(interrupt), .exception(exception), .PC(PC), .IF_ID(IF_ID)
  );

  // Instruction memory contents: an arbitrary but address-unique pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign inst_data = mem_word(inst_addr);

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic [64:0] m_ifid;

  always @(posedge clk) begin
    logic [31:0] seq;
    logic        redirect;
    logic [31:0] tgt;
    seq      = {m_pc[31], 31'((m_pc[30:0] + 31'd4))};
    redirect = 1'b0;
    tgt      = 32'd0;
    if (!reset_b) begin
      m_pc   = 32'h8000_0000;
      m_ifid = 65'd0;
    end else if (!uart_wait) begin
      if (interrupt)                 begin redirect = 1'b1; tgt = 32'h8000_0004; end
      else if (exception)            begin redirect = 1'b1; tgt = 32'h8000_0008; end
      else if (branch_taken)         begin redirect = 1'b1; tgt = branch_address; end
      else if (!bubble && PCSrcJR)   begin redirect = 1'b1; tgt = jr_address; end
      else if (!bubble && PCSrcJ)    begin redirect = 1'b1; tgt = jump_address; end
      if (redirect) begin
        m_pc   = {tgt[31:2], 2'b00};
        m_ifid = 65'd0;
      end else if (!bubble) begin
        m_ifid = {1'b1, seq, mem_word(m_pc)};
        m_pc   = seq;
      end
    end
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("model_pc", {33'd0, PC}, {33'd0, m_pc});
      check("model_inst_addr", {33'd0, inst_addr}, {33'd0, m_pc});
      check("model_if_id", IF_ID, m_ifid);
      $display("t=%0t PC=%h IF_ID=%h", $time, PC, IF_ID);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    uart_wait = 0; bubble = 0; PCSrcJ = 0; PCSrcJR = 0;
    jump_address = 0; jr_address = 0; branch_taken = 0; branch_address = 0;
    interrupt = 0; exception = 0;
  endtask

  task automatic branch_to(input logic [31:0] a);
    branch_taken = 1; branch_address = a;
    step();
    branch_taken = 0; branch_address = 0;
  endtask

  initial begin
    clear_inputs();
    reset_b = 0;
    step();
    check_en = 1;
    step();
    check("reset_pc", {33'd0, PC}, {33'd0, 32'h8000_0000});
    check("reset_if_id", IF_ID, 65'd0);

    // Free run after reset.
    reset_b = 1;
    step();
    check("run1_pc", {33'd0, PC}, {33'd0, 32'h8000_0004});
    check("run1_if_id", IF_ID, {1'b1, 32'h8000_0004, mem_word(32'h8000_0000)});
    step();
    check("run2_pc", {33'd0, PC}, {33'd0, 32'h8000_0008});
    step();
    check("run3_pc", {33'd0, PC}, {33'd0, 32'h8000_000C});
    check("run3_if_id", IF_ID, {1'b1, 32'h8000_000C, mem_word(32'h8000_0008)});

    // Bubble holds two cycles (branch target low bits ignored).
    branch_to(32'h0000_000F);
    check("align_pc", {33'd0, PC}, {33'd0, 32'h0000_000C});
    check("flush_if_id", IF_ID, 65'd0);
    step();
    bubble = 1;
    step();
    step();
    check("bubble_pc", {33'd0, PC}, {33'd0, 32'h0000_0010});
    check("bubble_if_id", IF_ID, {1'b1, 32'h0000_0010, mem_word(32'h0000_000C)});
    bubble = 0;
    step();
    check("unbubble_pc", {33'd0, PC}, {33'd0, 32'h0000_0014});

    // Jump deferred by bubble.
    branch_to(32'h0000_001C);
    step();
    PCSrcJ = 1; jump_address = 32'h0000_0100; bubble = 1;
    step();
    check("jbub_pc", {33'd0, PC}, {33'd0, 32'h0000_0020});
    bubble = 0;
    step();
    check("jump_pc", {33'd0, PC}, {33'd0, 32'h0000_0100});
    check("jump_if_id", IF_ID, 65'd0);
    clear_inputs();
    step();

    // Branch beats concurrent jr.
    branch_taken = 1; branch_address = 32'h0000_0040;
    PCSrcJR = 1; jr_address = 32'h0000_0080;
    step();
    check("br_vs_jr_pc", {33'd0, PC}, {33'd0, 32'h0000_0040});
    check("br_vs_jr_if_id", IF_ID, 65'd0);
    clear_inputs();
    step();

    // Branch with bubble still redirects.
    branch_taken = 1; branch_address = 32'h0000_0300; bubble = 1;
    step();
    check("br_bubble_pc", {33'd0, PC}, {33'd0, 32'h0000_0300});
    clear_inputs();

    // jr alone, misaligned target.
    PCSrcJR = 1; jr_address = 32'h0000_0203;
    step();
    check("jr_pc", {33'd0, PC}, {33'd0, 32'h0000_0200});
    clear_inputs();
    step();

    // Freeze overrides interrupt/exception/branch.
    uart_wait = 1; interrupt = 1; exception = 1;
    branch_taken = 1; branch_address = 32'h0000_0500;
    step();
    step();
    check("freeze_pc", {33'd0, PC}, {33'd0, 32'h0000_0204});
    uart_wait = 0;
    step();
    check("irq_pc", {33'd0, PC}, {33'd0, 32'h8000_0004});
    check("irq_if_id", IF_ID, 65'd0);
    clear_inputs();
    exception = 1;
    step();
    check("exc_pc", {33'd0, PC}, {33'd0, 32'h8000_0008});
    clear_inputs();

    // Increment wrap keeps bit 31.
    branch_to(32'h7FFF_FFFC);
    step();
    check("wrap_lo_pc", {33'd0, PC}, {33'd0, 32'h0000_0000});
    check("wrap_lo_if_id", IF_ID, {1'b1, 32'h0000_0000, mem_word(32'h7FFF_FFFC)});
    branch_to(32'hFFFF_FFFC);
    step();
    check("wrap_hi_pc", {33'd0, PC}, {33'd0, 32'h8000_0000});

    // Reset mid-stall and under freeze.
    step();
    bubble = 1; reset_b = 0;
    step();
    check("rst_stall_pc", {33'd0, PC}, {33'd0, 32'h8000_0000});
    clear_inputs();
    reset_b = 1;
    step();
    step();
    uart_wait = 1; interrupt = 1; reset_b = 0;
    step();
    check("rst_freeze_pc", {33'd0, PC}, {33'd0, 32'h8000_0000});
    check("rst_freeze_if_id", IF_ID, 65'd0);
    clear_inputs();
    reset_b = 1;

    // Sparse random activity, checked by the model.
    for (int i = 0; i < 60; i++) begin
      uart_wait      = ($urandom_range(0, 9) == 0);
      bubble         = ($urandom_range(0, 4) == 0);
      PCSrcJ         = ($urandom_range(0, 7) == 0);
      PCSrcJR        = ($urandom_range(0, 9) == 0);
      branch_taken   = ($urandom_range(0, 9) == 0);
      interrupt      = ($urandom_range(0, 19) == 0);
      exception      = ($urandom_range(0, 19) == 0);
      jump_address   = $urandom;
      jr_address     = $urandom;
      branch_address = $urandom;
      step();
    end
    clear_inputs();
    step();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
